// File: rtl/pwm_cfg_pkg.sv
// Shared types and constants for the PWM configuration scheduler.
// Holds the commit FSM encoding, the register address map and reset values.
package pwm_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_DONE
  } state_t;

  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_ENABLE = 3'd5;
  localparam logic [2:0] ADDR_CTRL   = 3'd6;

  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_CLR_ERR = 1;

  // Replicated across the parameterised width at the point of use.
  localparam logic RST_PERIOD_BIT = 1'b1;
  localparam logic RST_DUTY_BIT   = 1'b0;
  localparam logic RST_ENABLE_BIT = 1'b0;
  localparam logic RST_ERR        = 1'b0;

endpackage

// File: rtl/pwm_cfg_regfile.sv
// Shadow registers, address decode and sticky error flag.
// Writes land one cycle after acceptance; commit is a same-cycle strobe.
module pwm_cfg_regfile
  import pwm_cfg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_fire,
  input  logic [2:0]              wr_addr,
  input  logic [CNT_W-1:0]        wr_data,
  output logic [CNT_W-1:0]        period_sh,
  output logic [NUM_CH*CNT_W-1:0] duty_sh,
  output logic [NUM_CH-1:0]       enable_sh,
  output logic                    err,
  output logic                    commit
);

  logic addr_duty, addr_period, addr_enable, addr_ctrl;
  logic err_set, err_clr;

  always_comb begin
    addr_duty   = int'(wr_addr) < NUM_CH;
    addr_period = (wr_addr == ADDR_PERIOD);
    addr_enable = (wr_addr == ADDR_ENABLE);
    addr_ctrl   = (wr_addr == ADDR_CTRL);
    err_set     = wr_fire && (!(addr_duty || addr_period || addr_enable || addr_ctrl) ||
                              (addr_period && (wr_data == '0)));
    err_clr     = wr_fire && addr_ctrl && wr_data[CTRL_CLR_ERR];
    commit      = wr_fire && addr_ctrl && wr_data[CTRL_COMMIT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_sh <= {CNT_W{RST_PERIOD_BIT}};
      duty_sh   <= {(NUM_CH*CNT_W){RST_DUTY_BIT}};
      enable_sh <= {NUM_CH{RST_ENABLE_BIT}};
      err       <= RST_ERR;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_fire && (int'(wr_addr) == i))
          duty_sh[i*CNT_W +: CNT_W] <= wr_data;
      end
      // A zero period would stall the counter, so it never reaches the shadow.
      if (wr_fire && addr_period && (wr_data != '0))
        period_sh <= wr_data;
      if (wr_fire && addr_enable)
        enable_sh <= wr_data[NUM_CH-1:0];
      if (err_set)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule

// File: rtl/pwm_cfg_scheduler.sv
// Commits shadow PWM settings to the active outputs atomically at a period boundary.
// Load happens on the first pwm_wrap seen in PENDING (or at once if all channels are off); writes are stalled until then.
module pwm_cfg_scheduler
  import pwm_cfg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [2:0]              wr_addr,
  input  logic [CNT_W-1:0]        wr_data,
  input  logic                    pwm_wrap,
  output logic [CNT_W-1:0]        period,
  output logic [NUM_CH*CNT_W-1:0] duty,
  output logic [NUM_CH-1:0]       enable,
  output logic                    update_pending,
  output logic                    update_done,
  output logic                    err
);

  state_t                    state, state_nxt;
  logic                      load, commit, wr_fire;
  logic [CNT_W-1:0]          period_sh;
  logic [NUM_CH*CNT_W-1:0]   duty_sh, duty_clamped;
  logic [NUM_CH-1:0]         enable_sh;

  assign wr_ready = (state == ST_IDLE);
  assign wr_fire  = wr_valid && wr_ready;

  pwm_cfg_regfile #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wr_fire   (wr_fire),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .period_sh (period_sh),
    .duty_sh   (duty_sh),
    .enable_sh (enable_sh),
    .err       (err),
    .commit    (commit)
  );

  always_comb begin
    logic [CNT_W-1:0] d;
    duty_clamped = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      d = duty_sh[i*CNT_W +: CNT_W];
      duty_clamped[i*CNT_W +: CNT_W] = (d > period_sh) ? period_sh : d;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE:    if (commit) state_nxt = ST_PENDING;
      // With every channel off no wrap will ever arrive, so load immediately.
      ST_PENDING: if (pwm_wrap || (enable == '0)) begin
                    load      = 1'b1;
                    state_nxt = ST_DONE;
                  end
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      update_pending <= 1'b0;
      update_done    <= 1'b0;
      period         <= {CNT_W{RST_PERIOD_BIT}};
      duty           <= {(NUM_CH*CNT_W){RST_DUTY_BIT}};
      enable         <= {NUM_CH{RST_ENABLE_BIT}};
    end else begin
      state          <= state_nxt;
      update_pending <= (state_nxt == ST_PENDING);
      update_done    <= (state_nxt == ST_DONE);
      if (load) begin
        period <= period_sh;
        duty   <= duty_clamped;
        enable <= enable_sh;
      end
    end
  end

endmodule
